sram_word_ctrl: RTL

Multi-cycle controller between the MEM stage and a 16-bit off-chip SRAM. It replaces the single-cycle data memory with a two-half-word access sequence per 32-bit word. While an access is in flight it holds `ready` low so the pipeline freezes. It returns the assembled read word on `MEM_result` in the same address space as the data memory: word index = (address − 1024) >> 2.

---
 rtl/sram_word_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sram_word_ctrl.sv
// rtl/sram_word_ctrl.sv - MEM-stage data memory over a 16-bit SRAM, two half-word accesses per word
// Optional macro SRAM_RANGE_CHECK_EN: faulting requests go straight to DONE and raise addr_err.
module sram_word_ctrl #(
  parameter int ACCESS_CYCLES = 2,
  parameter int SRAM_AW       = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               MEMread,
  input  logic               MEMwrite,
  input  logic [31:0]        address,
  input  logic [31:0]        data,
  output logic [31:0]        MEM_result,
  output logic               ready,
  output logic               addr_err,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [15:0]        SRAM_DQ_OUT,
  output logic               SRAM_DQ_OE,
  input  logic [15:0]        SRAM_DQ_IN,
  output logic               SRAM_WE_N
);

  localparam int IW = SRAM_AW - 1;
  localparam int CW = $clog2(ACCESS_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] idx_q;
  logic [31:0]   data_q;
  logic [15:0]   lo_q;
  logic          req, last, fault, in_half;
  logic [31:0]   offset;

  assign req     = MEMread | MEMwrite;
  assign last    = (cnt_q == LAST);
  assign offset  = address - 32'd1024;
  assign in_half = (state_q != IDLE) && (state_q != DONE);

`ifdef SRAM_RANGE_CHECK_EN
  logic err_q;

  // Index overflow shows up as any nonzero bit above the SRAM word-index field.
  assign fault    = (address < 32'd1024) | (address[1:0] != 2'b00) | (offset[31:IW+2] != '0);
  assign addr_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state_q == IDLE) & req & fault;
    end
  end
`else
  logic unused_offset_bits;

  assign fault              = 1'b0;
  assign addr_err           = 1'b0;
  assign unused_offset_bits = ^{offset[1:0], offset[31:IW+2]};
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (fault)        state_d = DONE;
          else if (MEMread) state_d = RD_LO;
          else              state_d = WR_LO;
        end
      end
      RD_LO:   if (last) state_d = RD_HI;
      RD_HI:   if (last) state_d = DONE;
      WR_LO:   if (last) state_d = WR_HI;
      WR_HI:   if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      lo_q       <= '0;
      MEM_result <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) cnt_q <= '0;
      else if (in_half)       cnt_q <= cnt_q + 1'b1;

      if (state_q == IDLE && req) begin
        idx_q  <= offset[IW+1:2];
        data_q <= data;
        if (fault && MEMread) MEM_result <= '0;
      end

      if (state_q == RD_LO && last) lo_q       <= SRAM_DQ_IN;
      if (state_q == RD_HI && last) MEM_result <= {SRAM_DQ_IN, lo_q};
    end
  end

  // SRAM bus is decoded from state alone so it changes exactly at state boundaries.
  always_comb begin
    SRAM_ADDR   = {idx_q, 1'b0};
    SRAM_WE_N   = 1'b1;
    SRAM_DQ_OE  = 1'b0;
    SRAM_DQ_OUT = '0;
    case (state_q)
      RD_HI: SRAM_ADDR = {idx_q, 1'b1};
      WR_LO: begin
        SRAM_WE_N   = 1'b0;
        SRAM_DQ_OE  = 1'b1;
        SRAM_DQ_OUT = data_q[15:0];
      end
      WR_HI: begin
        SRAM_ADDR   = {idx_q, 1'b1};
        SRAM_WE_N   = 1'b0;
        SRAM_DQ_OE  = 1'b1;
        SRAM_DQ_OUT = data_q[31:16];
      end
      default: ;
    endcase
  end

  assign ready = ((state_q == IDLE) & ~req) | (state_q == DONE);

endmodule
